// File: rtl/programmable_clock_source.sv
// programmable_clock_source: multi-channel clock generator whose configuration is shadowed and applied only at period boundaries
module programmable_clock_source #(
   parameter  int NUM_CHANNELS = 4,
   parameter  int CNT_WIDTH    = 16,
   localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [CH_W-1:0]         cfg_channel,
   input  logic [CNT_WIDTH-1:0]    cfg_period,
   input  logic [CNT_WIDTH-1:0]    cfg_high,
   input  logic                    cfg_init,
   input  logic                    cfg_enable,
   output logic                    cfg_err,
   output logic [NUM_CHANNELS-1:0] clk_out,
   output logic [NUM_CHANNELS-1:0] rise_pulse,
   output logic [NUM_CHANNELS-1:0] running
);
   typedef enum logic {IDLE, RUN} state_t;
   logic [NUM_CHANNELS-1:0] w_pend;
   logic                    w_fire, w_bad, w_pend_sel, w_in_range;
   logic                    r_err;
   assign w_in_range = 32'(cfg_channel) < NUM_CHANNELS;
   always_comb begin
      w_pend_sel = 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++)
         if (cfg_channel == CH_W'(i)) w_pend_sel = w_pend[i];
   end
   assign cfg_ready = !reset && w_in_range && !w_pend_sel;
   assign w_fire    = cfg_valid && cfg_ready;
   assign w_bad     = cfg_enable && (cfg_period < CNT_WIDTH'(2) || cfg_high == '0 || cfg_high >= cfg_period);
   assign cfg_err   = r_err;
   always_ff @(posedge clock) begin
      if (reset) r_err <= 1'b0;
      else       r_err <= w_fire && w_bad;
   end
   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
      state_t               r_state;
      logic [CNT_WIDTH-1:0] r_cnt, r_per, r_high, r_s_per, r_s_high;
      logic                 r_init, r_s_init, r_s_en, r_pend, r_clk, r_rise;
      logic                 w_hit, w_wrap, w_ld_cfg, w_ld_sh, w_en_n, w_init_n, w_clk_n;
      logic [CNT_WIDTH-1:0] w_cnt_n, w_per_n, w_high_n;
      assign w_hit    = w_fire && !w_bad && cfg_channel == CH_W'(g);
      assign w_wrap   = r_state == RUN && r_cnt == r_per - 1'b1;
      // an idle channel takes a write straight away; a running one waits for its wrap
      assign w_ld_cfg = r_state == IDLE && w_hit;
      assign w_ld_sh  = w_wrap && r_pend;
      assign w_en_n   = w_ld_cfg ? cfg_enable : w_ld_sh ? r_s_en   : r_state == RUN;
      assign w_per_n  = w_ld_cfg ? cfg_period : w_ld_sh ? r_s_per  : r_per;
      assign w_high_n = w_ld_cfg ? cfg_high   : w_ld_sh ? r_s_high : r_high;
      assign w_init_n = w_ld_cfg ? cfg_init   : w_ld_sh ? r_s_init : r_init;
      assign w_cnt_n  = (r_state == IDLE || w_wrap) ? '0 : r_cnt + 1'b1;
      assign w_clk_n  = w_en_n && (w_init_n ? w_cnt_n < w_high_n : w_cnt_n >= w_per_n - w_high_n);
      always_ff @(posedge clock) begin
         if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_per    <= '0;
            r_high   <= '0;
            r_init   <= 1'b0;
            r_s_per  <= '0;
            r_s_high <= '0;
            r_s_init <= 1'b0;
            r_s_en   <= 1'b0;
            r_pend   <= 1'b0;
            r_clk    <= 1'b0;
            r_rise   <= 1'b0;
         end else begin
            r_state <= w_en_n ? RUN : IDLE;
            r_cnt   <= w_cnt_n;
            r_per   <= w_per_n;
            r_high  <= w_high_n;
            r_init  <= w_init_n;
            r_clk   <= w_clk_n;
            r_rise  <= w_clk_n && !r_clk;
            r_pend  <= w_ld_sh ? 1'b0 : r_pend || (w_hit && r_state == RUN);
            if (w_hit) begin
               r_s_per  <= cfg_period;
               r_s_high <= cfg_high;
               r_s_init <= cfg_init;
               r_s_en   <= cfg_enable;
            end
         end
      end
      assign clk_out[g]    = r_clk;
      assign rise_pulse[g] = r_rise;
      assign running[g]    = r_state == RUN;
      assign w_pend[g]     = r_pend;
   end
endmodule

// File: tb/tb_programmable_clock_source.sv
// tb_programmable_clock_source: scoreboard checks of waveforms, boundary reconfiguration, rejection and reset
module tb_programmable_clock_source;
   localparam int NC = 4;
   localparam int CW = 16;
   logic          clock = 1'b0, reset = 1'b1, cfg_valid = 1'b0, cfg_init = 1'b0, cfg_enable = 1'b0;
   logic          cfg_ready, cfg_err;
   logic [1:0]    cfg_channel = '0;
   logic [CW-1:0] cfg_period = '0, cfg_high = '0;
   logic [NC-1:0] clk_out, rise_pulse, running;
   logic [12:0]   q[$];
   logic [3:0]    last = '0;
   int            n_chk = 0, n_fail = 0;
   always #5 clock = ~clock;
   programmable_clock_source #(.NUM_CHANNELS(NC), .CNT_WIDTH(CW)) dut (
      .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_channel(cfg_channel), .cfg_period(cfg_period), .cfg_high(cfg_high),
      .cfg_init(cfg_init), .cfg_enable(cfg_enable), .cfg_err(cfg_err),
      .clk_out(clk_out), .rise_pulse(rise_pulse), .running(running)
   );
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   task automatic drive(input int ch, input int per, input int high, input int init, input int en, input int vld);
      cfg_channel = 2'(ch);
      cfg_period  = CW'(per);
      cfg_high    = CW'(high);
      cfg_init    = 1'(init);
      cfg_enable  = 1'(en);
      cfg_valid   = 1'(vld);
   endtask
   task automatic write(input int ch, input int per, input int high, input int init, input int en);
      drive(ch, per, high, init, en, 1);
      step();
      cfg_valid = 1'b0;
   endtask
   // expected entry: {clk_out, rise_pulse, running, cfg_err}; rise derives from the previous expected clk
   task automatic push(input logic [3:0] c, input logic [3:0] r, input logic er);
      q.push_back({c, c & ~last, r, er});
      last = c;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      cfg_valid = 1'b0;
      step();
      step();
      reset = 1'b0;
      last = '0;
      q.delete();
   endtask
   task automatic test_reset();
      reset = 1'b1;
      #1;
      n_chk++;
      if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", cfg_ready); end
      step();
      step();
      n_chk++;
      if ({clk_out, rise_pulse, running, cfg_err} !== 13'b0) begin
         n_fail++; $display("FAIL reset_outputs got %h exp 0", {clk_out, rise_pulse, running, cfg_err});
      end
      reset = 1'b0;
      #1;
      n_chk++;
      if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got %b exp 1", cfg_ready); end
   endtask
   task automatic test_ch0_wave();
      logic [12:0] e;
      do_reset();
      write(0, 4, 1, 1, 1);
      for (int k = 0; k < 12; k++) push({3'b0, (k % 4 == 0)}, 4'b0001, 1'b0);
      for (int k = 0; k < 12; k++) begin
         if (k > 0) step();
         e = q.pop_front();
         n_chk++;
         if ({clk_out, rise_pulse, running, cfg_err} !== e) begin
            n_fail++; $display("FAIL ch0_wave k=%0d got %h exp %h", k, {clk_out, rise_pulse, running, cfg_err}, e);
         end
      end
   endtask
   task automatic test_ch1_wave();
      logic [12:0] e;
      do_reset();
      write(1, 5, 2, 0, 1);
      for (int k = 0; k < 10; k++) push({2'b0, (k % 5 >= 3), 1'b0}, 4'b0010, 1'b0);
      for (int k = 0; k < 10; k++) begin
         if (k > 0) step();
         e = q.pop_front();
         n_chk++;
         if ({clk_out, rise_pulse, running, cfg_err} !== e) begin
            n_fail++; $display("FAIL ch1_wave k=%0d got %h exp %h", k, {clk_out, rise_pulse, running, cfg_err}, e);
         end
      end
   endtask
   task automatic test_back_to_back();
      logic [12:0] e;
      logic [14:0] rdy;
      do_reset();
      write(0, 4, 1, 1, 1);
      rdy = 15'b111110000010001;
      for (int k = 0; k < 15; k++)
         push({3'b0, (k < 4) ? (k == 0) : (k < 10) ? (k < 7) : ((k - 10) % 4 == 0)}, 4'b0001, 1'b0);
      for (int k = 0; k < 15; k++) begin
         if (k > 0) step();
         e = q.pop_front();
         n_chk++;
         if ({clk_out, rise_pulse, running, cfg_err} !== e) begin
            n_fail++; $display("FAIL reconfig_wave k=%0d got %h exp %h", k, {clk_out, rise_pulse, running, cfg_err}, e);
         end
         n_chk++;
         if (cfg_ready !== rdy[k]) begin n_fail++; $display("FAIL reconfig_ready k=%0d got %b exp %b", k, cfg_ready, rdy[k]); end
         if (k == 0) drive(0, 6, 3, 1, 1, 1);
         else if (k == 1) drive(0, 4, 1, 1, 1, 1);
         else if (k == 5) cfg_valid = 1'b0;
      end
   endtask
   task automatic test_reject();
      logic [12:0] e;
      do_reset();
      write(2, 4, 2, 1, 1);
      for (int k = 0; k < 10; k++) push({1'b0, (k % 4 < 2), 2'b0}, 4'b0100, (k == 2 || k == 5 || k == 7));
      for (int k = 0; k < 10; k++) begin
         if (k > 0) step();
         e = q.pop_front();
         n_chk++;
         if ({clk_out, rise_pulse, running, cfg_err} !== e) begin
            n_fail++; $display("FAIL reject k=%0d got %h exp %h", k, {clk_out, rise_pulse, running, cfg_err}, e);
         end
         if (k == 1) drive(2, 4, 4, 1, 1, 1);
         else if (k == 4) drive(2, 1, 0, 1, 1, 1);
         else if (k == 6) drive(2, 5, 0, 1, 1, 1);
         else cfg_valid = 1'b0;
      end
   endtask
   task automatic test_disable();
      logic [12:0] e;
      do_reset();
      write(0, 4, 1, 1, 1);
      for (int k = 0; k < 12; k++)
         push({2'b0, (k >= 1 && (k - 1) % 5 >= 3), (k == 0)}, {2'b0, (k >= 1), (k < 4)}, 1'b0);
      for (int k = 0; k < 12; k++) begin
         if (k > 0) step();
         e = q.pop_front();
         n_chk++;
         if ({clk_out, rise_pulse, running, cfg_err} !== e) begin
            n_fail++; $display("FAIL disable k=%0d got %h exp %h", k, {clk_out, rise_pulse, running, cfg_err}, e);
         end
         if (k == 2 || k == 4) begin
            n_chk++;
            if (cfg_ready !== (k == 4)) begin n_fail++; $display("FAIL disable_ready k=%0d got %b exp %b", k, cfg_ready, k == 4); end
         end
         if (k == 0) drive(1, 5, 2, 0, 1, 1);
         else if (k == 1) drive(0, 0, 0, 0, 0, 1);
         else cfg_valid = 1'b0;
      end
   endtask
   task automatic test_reset_mid();
      logic [12:0] e;
      logic [3:0]  v;
      do_reset();
      write(0, 4, 1, 1, 1);
      write(1, 5, 2, 0, 1);
      write(2, 4, 2, 1, 1);
      write(3, 3, 1, 0, 1);
      for (int k = -1; k < 4; k++) begin
         v = {(k >= 0 && k % 3 >= 2), ((1 + k) % 4 < 2), ((2 + k) % 5 >= 3), ((3 + k) % 4 < 1)};
         if (k < 0) last = v;
         else push(v, 4'b1111, 1'b0);
      end
      for (int k = 0; k < 4; k++) begin
         if (k > 0) step();
         e = q.pop_front();
         n_chk++;
         if ({clk_out, rise_pulse, running, cfg_err} !== e) begin
            n_fail++; $display("FAIL all_run k=%0d got %h exp %h", k, {clk_out, rise_pulse, running, cfg_err}, e);
         end
      end
      reset = 1'b1;
      #1;
      n_chk++;
      if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready got %b exp 0", cfg_ready); end
      for (int k = 0; k < 5; k++) push(4'b0, 4'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step();
         if (k == 0) begin
            reset = 1'b0;
            #1;
            n_chk++;
            if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b exp 1", cfg_ready); end
         end
         e = q.pop_front();
         n_chk++;
         if ({clk_out, rise_pulse, running, cfg_err} !== e) begin
            n_fail++; $display("FAIL after_reset k=%0d got %h exp %h", k, {clk_out, rise_pulse, running, cfg_err}, e);
         end
      end
   endtask
   initial begin
      test_reset();
      test_ch0_wave();
      test_ch1_wave();
      test_back_to_back();
      test_reject();
      test_disable();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
